// File: rtl/nf_store_split.sv
// Store-side narrowing unit: places byte/half/word store data on the correct lanes of a
// 32-bit write bus, splitting word-boundary-crossing stores into two aligned beats.
module nf_store_split #(
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        bus_vld,
    input  logic        bus_rdy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [1:0]  off_s;
    logic [3:0]  mask_s;
    logic [31:0] data_masked_s;
    logic [7:0]  be8_s;
    logic [63:0] wd64_s;
    logic        cross_s;
    logic        reject_s;

    logic        bus_vld_r;
    logic [31:0] bus_addr_r;
    logic [31:0] bus_wdata_r;
    logic [3:0]  bus_be_r;
    logic        done_r;
    logic        err_r;
    logic [31:0] hi_wdata_r;
    logic [3:0]  hi_be_r;

    logic        bus_vld_nxt_s;
    logic [31:0] bus_addr_nxt_s;
    logic [31:0] bus_wdata_nxt_s;
    logic [3:0]  bus_be_nxt_s;
    logic        done_nxt_s;
    logic        err_nxt_s;
    logic [31:0] hi_wdata_nxt_s;
    logic [3:0]  hi_be_nxt_s;

    // Lane placement of the incoming request; bytes outside the access size are zeroed.
    always_comb begin
        off_s = req_addr[1:0];
        case (req_size)
            2'b00:   mask_s = 4'b0001;
            2'b01:   mask_s = 4'b0011;
            2'b10:   mask_s = 4'b1111;
            default: mask_s = 4'b0000;
        endcase
        data_masked_s = req_data & {{8{mask_s[3]}}, {8{mask_s[2]}}, {8{mask_s[1]}}, {8{mask_s[0]}}};
        be8_s         = {4'b0000, mask_s} << off_s;
        wd64_s        = {32'h0000_0000, data_masked_s} << {off_s, 3'b000};
        cross_s       = |be8_s[7:4];
        reject_s      = (req_size == 2'b11) || (cross_s && (ALLOW_MISALIGN == 1'b0));
    end

    // Next-state and next-output decode; all bus outputs are held unless a beat is accepted.
    always_comb begin
        state_nxt_s     = state_r;
        bus_vld_nxt_s   = bus_vld_r;
        bus_addr_nxt_s  = bus_addr_r;
        bus_wdata_nxt_s = bus_wdata_r;
        bus_be_nxt_s    = bus_be_r;
        hi_wdata_nxt_s  = hi_wdata_r;
        hi_be_nxt_s     = hi_be_r;
        done_nxt_s      = 1'b0;
        err_nxt_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_vld) begin
                    if (reject_s) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s     = ST_BEAT0;
                        bus_vld_nxt_s   = 1'b1;
                        bus_addr_nxt_s  = {req_addr[31:2], 2'b00};
                        bus_wdata_nxt_s = wd64_s[31:0];
                        bus_be_nxt_s    = be8_s[3:0];
                        hi_wdata_nxt_s  = wd64_s[63:32];
                        hi_be_nxt_s     = be8_s[7:4];
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BEAT0: begin
                if (bus_rdy) begin
                    if (|hi_be_r) begin
                        // Second beat goes to the next word; address wraps modulo 2^32.
                        state_nxt_s     = ST_BEAT1;
                        bus_addr_nxt_s  = bus_addr_r + 32'd4;
                        bus_wdata_nxt_s = hi_wdata_r;
                        bus_be_nxt_s    = hi_be_r;
                    end else begin
                        state_nxt_s     = ST_IDLE;
                        done_nxt_s      = 1'b1;
                        bus_vld_nxt_s   = 1'b0;
                        bus_addr_nxt_s  = 32'h0000_0000;
                        bus_wdata_nxt_s = 32'h0000_0000;
                        bus_be_nxt_s    = 4'b0000;
                    end
                end else begin
                    state_nxt_s = ST_BEAT0;
                end
            end
            ST_BEAT1: begin
                if (bus_rdy) begin
                    state_nxt_s     = ST_IDLE;
                    done_nxt_s      = 1'b1;
                    bus_vld_nxt_s   = 1'b0;
                    bus_addr_nxt_s  = 32'h0000_0000;
                    bus_wdata_nxt_s = 32'h0000_0000;
                    bus_be_nxt_s    = 4'b0000;
                end else begin
                    state_nxt_s = ST_BEAT1;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                bus_vld_nxt_s   = 1'b0;
                bus_addr_nxt_s  = 32'h0000_0000;
                bus_wdata_nxt_s = 32'h0000_0000;
                bus_be_nxt_s    = 4'b0000;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered bus outputs, status pulses and the latched upper-beat payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_vld_r   <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
            bus_be_r    <= 4'b0000;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            hi_wdata_r  <= 32'h0000_0000;
            hi_be_r     <= 4'b0000;
        end else begin
            bus_vld_r   <= bus_vld_nxt_s;
            bus_addr_r  <= bus_addr_nxt_s;
            bus_wdata_r <= bus_wdata_nxt_s;
            bus_be_r    <= bus_be_nxt_s;
            done_r      <= done_nxt_s;
            err_r       <= err_nxt_s;
            hi_wdata_r  <= hi_wdata_nxt_s;
            hi_be_r     <= hi_be_nxt_s;
        end
    end

    assign req_rdy   = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign bus_vld   = bus_vld_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign bus_be    = bus_be_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_nf_store_split.sv
// Directed testbench for nf_store_split: one instance with misaligned splitting enabled,
// one with it disabled.
module tb_nf_store_split;

    logic        clk;
    logic        rst;
    logic        req_vld;
    logic        req_vld0;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        bus_rdy;

    logic        req_rdy, bus_vld, done, err, busy;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    logic        req_rdy0, bus_vld0, done0, err0, busy0;
    logic [31:0] bus_addr0, bus_wdata0;
    logic [3:0]  bus_be0;

    int checks;
    int errors;

    nf_store_split #(.ALLOW_MISALIGN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
        .req_data(req_data), .req_size(req_size),
        .bus_vld(bus_vld), .bus_rdy(bus_rdy), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .done(done), .err(err), .busy(busy)
    );

    nf_store_split #(.ALLOW_MISALIGN(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .req_vld(req_vld0), .req_rdy(req_rdy0), .req_addr(req_addr),
        .req_data(req_data), .req_size(req_size),
        .bus_vld(bus_vld0), .bus_rdy(bus_rdy), .bus_addr(bus_addr0),
        .bus_wdata(bus_wdata0), .bus_be(bus_be0),
        .done(done0), .err(err0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store_single(input string tag, input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size, input logic [31:0] ea,
                                input logic [31:0] ew, input logic [3:0] eb);
        check({tag, "_rdy_n"}, 32'(req_rdy), 32'd1);
        req_vld = 1'b1; req_addr = addr; req_data = data; req_size = size;
        step();
        req_vld = 1'b0;
        check({tag, "_vld"},   32'(bus_vld), 32'd1);
        check({tag, "_addr"},  bus_addr, ea);
        check({tag, "_wdata"}, bus_wdata, ew);
        check({tag, "_be"},    32'(bus_be), 32'(eb));
        check({tag, "_rdy_n1"}, 32'(req_rdy), 32'd0);
        check({tag, "_done_n1"}, 32'(done), 32'd0);
        step();
        check({tag, "_done"},  32'(done), 32'd1);
        check({tag, "_vld_n2"}, 32'(bus_vld), 32'd0);
        check({tag, "_busy_n2"}, 32'(busy), 32'd0);
        check({tag, "_rdy_n2"}, 32'(req_rdy), 32'd1);
        step();
        check({tag, "_done_n3"}, 32'(done), 32'd0);
    endtask

    task automatic store_split(input string tag, input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size,
                               input logic [31:0] ea0, input logic [31:0] ew0, input logic [3:0] eb0,
                               input logic [31:0] ea1, input logic [31:0] ew1, input logic [3:0] eb1,
                               input int stall);
        req_vld = 1'b1; req_addr = addr; req_data = data; req_size = size;
        step();
        req_vld = 1'b0;
        check({tag, "_b0_vld"},   32'(bus_vld), 32'd1);
        check({tag, "_b0_addr"},  bus_addr, ea0);
        check({tag, "_b0_wdata"}, bus_wdata, ew0);
        check({tag, "_b0_be"},    32'(bus_be), 32'(eb0));
        step();
        check({tag, "_b1_vld"},   32'(bus_vld), 32'd1);
        check({tag, "_b1_addr"},  bus_addr, ea1);
        check({tag, "_b1_wdata"}, bus_wdata, ew1);
        check({tag, "_b1_be"},    32'(bus_be), 32'(eb1));
        check({tag, "_b1_done"},  32'(done), 32'd0);
        bus_rdy = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            check({tag, "_hold_vld"},   32'(bus_vld), 32'd1);
            check({tag, "_hold_addr"},  bus_addr, ea1);
            check({tag, "_hold_wdata"}, bus_wdata, ew1);
            check({tag, "_hold_be"},    32'(bus_be), 32'(eb1));
            check({tag, "_hold_done"},  32'(done), 32'd0);
        end
        bus_rdy = 1'b1;
        step();
        check({tag, "_done"},  32'(done), 32'd1);
        check({tag, "_err"},   32'(err), 32'd0);
        check({tag, "_vld_end"}, 32'(bus_vld), 32'd0);
        step();
        check({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; req_vld = 1'b0; req_vld0 = 1'b0;
        req_addr = 32'h0; req_data = 32'h0; req_size = 2'b00; bus_rdy = 1'b1;
        step();
        step();
        check("rst_vld",   32'(bus_vld), 32'd0);
        check("rst_addr",  bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_be",    32'(bus_be), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_rdy",   32'(req_rdy), 32'd1);
        rst = 1'b0;
        step();

        store_single("byte",  32'h0000_0103, 32'h0000_00AB, 2'b00, 32'h0000_0100, 32'hAB00_0000, 4'b1000);
        store_single("half",  32'h0000_0202, 32'h0000_1234, 2'b01, 32'h0000_0200, 32'h1234_0000, 4'b1100);
        store_single("word",  32'h0000_0400, 32'h1122_3344, 2'b10, 32'h0000_0400, 32'h1122_3344, 4'b1111);
        store_single("bmask", 32'h0000_0101, 32'hFFFF_FF5A, 2'b00, 32'h0000_0100, 32'h0000_5A00, 4'b0010);

        store_split("misw", 32'h0000_0301, 32'hDDCC_BBAA, 2'b10,
                    32'h0000_0300, 32'hCCBB_AA00, 4'b1110,
                    32'h0000_0304, 32'h0000_00DD, 4'b0001, 0);
        store_split("wrap", 32'hFFFF_FFFF, 32'h0000_1234, 2'b01,
                    32'hFFFF_FFFC, 32'h3400_0000, 4'b1000,
                    32'h0000_0000, 32'h0000_0012, 4'b0001, 3);

        // Illegal size on the splitting instance.
        req_vld = 1'b1; req_addr = 32'h0000_0100; req_data = 32'h0000_0055; req_size = 2'b11;
        step();
        req_vld = 1'b0;
        check("ill_err",  32'(err), 32'd1);
        check("ill_vld",  32'(bus_vld), 32'd0);
        check("ill_rdy",  32'(req_rdy), 32'd1);
        check("ill_done", 32'(done), 32'd0);
        step();
        check("ill_err_n2", 32'(err), 32'd0);
        check("ill_vld_n2", 32'(bus_vld), 32'd0);

        // Crossing word on the non-splitting instance.
        req_vld0 = 1'b1; req_addr = 32'h0000_0301; req_data = 32'hDDCC_BBAA; req_size = 2'b10;
        step();
        req_vld0 = 1'b0;
        check("nm_err",  32'(err0), 32'd1);
        check("nm_vld",  32'(bus_vld0), 32'd0);
        check("nm_rdy",  32'(req_rdy0), 32'd1);
        check("nm_busy", 32'(busy0), 32'd0);
        step();
        check("nm_err_n2", 32'(err0), 32'd0);
        check("nm_vld_n2", 32'(bus_vld0), 32'd0);

        // Non-crossing store still works on the non-splitting instance.
        req_vld0 = 1'b1; req_addr = 32'h0000_0103; req_data = 32'h0000_00AB; req_size = 2'b00;
        step();
        req_vld0 = 1'b0;
        check("nm_b_vld",   32'(bus_vld0), 32'd1);
        check("nm_b_wdata", bus_wdata0, 32'hAB00_0000);
        check("nm_b_be",    32'(bus_be0), 32'd8);
        step();
        check("nm_b_done",  32'(done0), 32'd1);
        check("nm_b_err",   32'(err0), 32'd0);
        step();

        // Reset while a beat is stalled.
        bus_rdy = 1'b0;
        req_vld = 1'b1; req_addr = 32'h0000_0103; req_data = 32'h0000_00AB; req_size = 2'b00;
        step();
        req_vld = 1'b0;
        check("mr_vld_b0", 32'(bus_vld), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_vld",  32'(bus_vld), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_rdy",  32'(req_rdy), 32'd1);
        check("mr_done", 32'(done), 32'd0);
        check("mr_err",  32'(err), 32'd0);
        bus_rdy = 1'b1;
        step();
        check("mr_done_n2", 32'(done), 32'd0);
        check("mr_vld_n2",  32'(bus_vld), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
